seq_mul_ctrl: RTL and testbench

//   Handshake front-end and sequencer for the 6-bit left-shift sequential multiplier.
//   - Accepts an operand pair over a valid/ready interface.
//   - Issues the one-cycle load pulse to the multiplier and counts its iteration cycles.
//   - Captures the finished product and holds it on a valid/ready result interface.
//   - Sits directly upstream of the multiplier (drives load/a/b) and consumes its product.

---
 rtl/seq_mul_ctrl.sv | 99 +++++++++
 tb/tb_seq_mul_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_ctrl.sv
// Handshake front-end and sequencer for a WIDTH-bit shift-add sequential multiplier.
// It accepts operands, issues the load pulse, times the iterations and holds the product.
module seq_mul_ctrl #(
  parameter int WIDTH   = 6,
  parameter int LATENCY = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 mul_load,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPT,
    DONE
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 mul_load_q;
  logic [WIDTH-1:0]     mul_a_q;
  logic [WIDTH-1:0]     mul_b_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 out_valid_q;

  // mul_load is raised on the accept edge so it is high for exactly the LOAD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mul_load_q  <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mul_a_q    <= in_a;
            mul_b_q    <= in_b;
            mul_load_q <= 1'b1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          mul_load_q <= 1'b0;
          cnt_q      <= '0;
          state_q    <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= CAPT;
          end
        end
        CAPT: begin
          result_q    <= mul_product;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mul_load  = mul_load_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Testbench for seq_mul_ctrl: drives directed operand pairs against a shift-add
// multiplier model and checks results through a scoreboard queue.
module tb_seq_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_a;
  logic [5:0]  in_b;
  logic        mul_load;
  logic [5:0]  mul_a;
  logic [5:0]  mul_b;
  logic [11:0] mul_product;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] result;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int loadCnt = 0;
  int riseCyc = -1;
  int lastAcc = 0;
  logic [11:0] sb[$];

  logic [11:0] acc;
  logic [11:0] mcand;
  logic [5:0]  mplier;

  seq_mul_ctrl #(.WIDTH(6), .LATENCY(6)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Left-shift multiplier model: one add/shift per edge after the load edge.
  always @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (mul_load) begin
      acc    <= '0;
      mcand  <= {6'd0, mul_a};
      mplier <= mul_b;
    end else begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
  assign mul_product = acc;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Monitor: inputs only change at negedges, so sampling just after one is stable.
  initial begin
    logic prevOv;
    logic [11:0] exp;
    prevOv = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (mul_load === 1'b1) loadCnt++;
      if (out_valid === 1'b1 && prevOv !== 1'b1) riseCyc = cyc;
      prevOv = out_valid;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", int'(result), -1);
        end else begin
          exp = sb.pop_front();
          checkOutput("result", int'(result), int'(exp));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [5:0] a, input logic [5:0] b,
                               input logic [11:0] exp, input bit hold);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checkOutput("accept_timeout", 0, 1);
    end else begin
      sb.push_back(exp);
      lastAcc = cyc + 1;
    end
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int base;
    int accEdges[3];
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_result", int'(result), 0);
    checkOutput("rst_mul_load", int'(mul_load), 0);
    checkOutput("rst_mul_a", int'(mul_a), 0);
    checkOutput("rst_mul_b", int'(mul_b), 0);

    base = loadCnt;
    applyStimulus(6'd63, 6'd63, 12'd3969, 1'b0);
    checkOutput("busy_in_load", int'(busy), 1);
    waitDone();
    checkOutput("max_load_pulses", loadCnt - base, 1);
    checkOutput("max_latency", riseCyc - lastAcc, 8);

    applyStimulus(6'd0, 6'd45, 12'd0, 1'b0);
    waitDone();
    applyStimulus(6'd1, 6'd45, 12'd45, 1'b0);
    waitDone();

    out_ready = 1'b0;
    applyStimulus(6'd7, 6'd9, 12'd63, 1'b0);
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_valid", int'(out_valid), 1);
      checkOutput("bp_result", int'(result), 63);
      checkOutput("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_drop", int'(out_valid), 0);
    checkOutput("bp_sb_empty", sb.size(), 0);

    base = loadCnt;
    applyStimulus(6'd5, 6'd6, 12'd30, 1'b0);
    @(negedge clk);
    in_a = 6'd2;
    in_b = 6'd2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("ign_mul_a", int'(mul_a), 5);
    checkOutput("ign_mul_b", int'(mul_b), 6);
    checkOutput("ign_in_ready", int'(in_ready), 0);
    waitDone();
    checkOutput("ign_load_pulses", loadCnt - base, 1);
    checkOutput("ign_hold_a", int'(mul_a), 5);

    applyStimulus(6'd9, 6'd9, 12'd81, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mrst_in_ready", int'(in_ready), 1);
    checkOutput("mrst_out_valid", int'(out_valid), 0);
    checkOutput("mrst_result", int'(result), 0);
    checkOutput("mrst_mul_load", int'(mul_load), 0);
    applyStimulus(6'd10, 6'd10, 12'd100, 1'b0);
    waitDone();

    // One op occupies IDLE, LOAD, six RUN cycles, CAPT and DONE: ten cycles.
    applyStimulus(6'd3, 6'd4, 12'd12, 1'b1);
    accEdges[0] = lastAcc;
    applyStimulus(6'd63, 6'd1, 12'd63, 1'b1);
    accEdges[1] = lastAcc;
    applyStimulus(6'd32, 6'd32, 12'd1024, 1'b0);
    accEdges[2] = lastAcc;
    waitDone();
    checkOutput("b2b_spacing1", accEdges[1] - accEdges[0], 10);
    checkOutput("b2b_spacing2", accEdges[2] - accEdges[1], 10);

    repeat (3) @(negedge clk);
    checkOutput("final_idle", int'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL global_timeout actual=%0d expected=%0d", cyc, 0);
    $fatal(1, "[TB] timeout");
  end

endmodule
